histo_readout: RTL and testbench

Slow-domain readout engine for the trigger board's per-channel trigger histograms. It accepts a command to either dump one channel or clear all histograms. For a dump it drives `histostosend`, waits for the value to reach the fast domain, then captures the eight 32-bit `histosout` words with a stability check. It serializes them as a checksummed byte frame on a valid/ready byte stream toward the host link. It is the reader for the histogram bank and the source of its `resethist` control, and runs entirely on the board's slow `clk`.

---
 rtl/trig_pkg.sv | 19 +
 rtl/byte_serializer.sv | 77 +++++++
 rtl/histo_readout.sv | 178 +++++++++++++++++
 tb/tb_histo_readout.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared constants and types for the trigger-board histogram readout path.
// Frame header values, frame length, FSM states and the histogram word type.
package trig_pkg;

    localparam logic [7:0] HDR_OK       = 8'hA5;
    localparam logic [7:0] HDR_UNSTABLE = 8'hA6;
    localparam int         FRAME_LEN    = 35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_SEND
    } state_t;

    typedef logic [31:0] hist_word_t;

endpackage

// File: rtl/byte_serializer.sv
// Turns a captured histogram buffer plus header/channel into a checksummed
// byte frame on a valid/ready stream; done_o pulses as the last byte is taken.
module byte_serializer
    import trig_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load_i,
    input  logic [7:0]        hdr_i,
    input  logic [7:0]        chan_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              done_o
);

    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    logic [DATA_W-1:0] buf_q;
    logic [7:0]        hdr_q;
    logic [7:0]        chan_q;
    logic [7:0]        csum_q;
    logic [5:0]        idx_q;
    logic              valid_q;
    logic [4:0]        byteSel;
    logic [7:0]        txByte;

    // Byte index 2..33 maps linearly onto the buffer, which is already little-endian per word.
    always_comb begin
        byteSel = 5'(idx_q - 6'd2);
        if (idx_q == 6'd0) begin
            txByte = hdr_q;
        end else if (idx_q == 6'd1) begin
            txByte = chan_q;
        end else if (idx_q == LAST_IDX) begin
            txByte = csum_q;
        end else begin
            txByte = buf_q[{byteSel, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_q   <= '0;
            hdr_q   <= '0;
            chan_q  <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            buf_q   <= data_i;
            hdr_q   <= hdr_i;
            chan_q  <= chan_i;
            csum_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && tx_ready_i) begin
            if (idx_q == LAST_IDX) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
            end else begin
                idx_q <= idx_q + 6'd1;
                if (idx_q != 6'd0) begin
                    csum_q <= csum_q ^ txByte;
                end
            end
        end
    end

    assign tx_data_o  = txByte;
    assign tx_valid_o = valid_q;
    assign done_o     = valid_q && tx_ready_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/histo_readout.sv
// Slow-domain readout engine: selects a histogram channel, waits for it to settle,
// captures it with a two-sample stability check and streams it out as a byte frame.
module histo_readout
    import trig_pkg::*;
#(
    parameter int NCHAN        = 16,
    parameter int NHIST        = 8,
    parameter int SETTLE       = 8,
    parameter int RESET_CYCLES = 16,
    parameter int MAX_RETRY    = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_reset,
    input  logic [7:0]            cmd_chan,
    input  logic [32*NHIST-1:0]   histos_in,
    output logic [7:0]            histostosend,
    output logic                  resethist,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] CLEAR_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [7:0]  RETRY_LAST  = 8'(MAX_RETRY - 1);
    localparam logic [8:0]  NCHAN_W     = 9'(NCHAN);

    state_t                  state_q, state_d;
    logic [7:0]              sel_q, sel_d;
    logic [7:0]              chan_q, chan_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic [7:0]              retry_q, retry_d;
    hist_word_t [NHIST-1:0]  a_q, a_d;
    hist_word_t [NHIST-1:0]  b_q, b_d;

    logic                    serLoad;
    logic [7:0]              serHdr;
    logic [7:0]              serChan;
    logic [32*NHIST-1:0]     serData;
    logic                    serDone;
    logic                    inRange;

    assign inRange = {1'b0, cmd_chan} < NCHAN_W;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        retry_d = retry_q;
        a_d     = a_q;
        b_d     = b_q;
        serLoad = 1'b0;
        serHdr  = HDR_OK;
        serChan = chan_q;
        serData = b_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    chan_d = cmd_chan;
                    cnt_d  = '0;
                    if (cmd_reset) begin
                        state_d = ST_CLEAR;
                    end else if (inRange) begin
                        sel_d   = cmd_chan;
                        phase_d = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        // Unknown channel: answer with an all-zero frame, bank select untouched.
                        serLoad = 1'b1;
                        serChan = cmd_chan;
                        serData = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SAMPLE: begin
                case (phase_q)
                    2'd0: begin
                        a_d     = histos_in;
                        phase_d = 2'd1;
                    end
                    2'd1: begin
                        b_d     = histos_in;
                        phase_d = 2'd2;
                    end
                    default: begin
                        if (a_q == b_q) begin
                            serLoad = 1'b1;
                            state_d = ST_SEND;
                        end else if (retry_q == RETRY_LAST) begin
                            serLoad = 1'b1;
                            serHdr  = HDR_UNSTABLE;
                            state_d = ST_SEND;
                        end else begin
                            retry_d = retry_q + 8'd1;
                            cnt_d   = '0;
                            state_d = ST_SETTLE;
                        end
                    end
                endcase
            end
            ST_SEND: begin
                if (serDone) begin
                    retry_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            chan_q  <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            retry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    byte_serializer #(
        .DATA_W (32*NHIST)
    ) u_ser (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (serLoad),
        .hdr_i      (serHdr),
        .chan_i     (serChan),
        .data_i     (serData),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .done_o     (serDone)
    );

    // resethist decodes straight from state so an async reset drops it at once.
    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign resethist    = (state_q == ST_CLEAR);
    assign histostosend = sel_q;

endmodule

// File: tb/tb_histo_readout.sv
// Scoreboard bench for histo_readout: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares every accepted byte and checks stall stability.
module tb_histo_readout;

    logic         clk = 1'b0;
    logic         nrst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_reset;
    logic [7:0]   cmd_chan;
    logic [255:0] histos_in;
    logic [7:0]   histostosend;
    logic         resethist;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;

    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    int           accCyc = 0;
    int           hsCount = 0;
    bit           latWatch = 0;
    bit           mute = 0;
    bit           randReady = 0;
    bit           prevStall = 0;
    logic [7:0]   prevData = 8'h00;
    logic [7:0]   expQ[$];

    histo_readout dut (
        .clk          (clk),
        .nrst         (nrst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_reset    (cmd_reset),
        .cmd_chan     (cmd_chan),
        .histos_in    (histos_in),
        .histostosend (histostosend),
        .resethist    (resethist),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [255:0] makeWords(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = base + step * k;
        return v;
    endfunction

    task automatic pushFrame(input logic [7:0] hdr, input logic [7:0] chan, input logic [255:0] data);
        logic [7:0] cs;
        logic [7:0] b;
        expQ.push_back(hdr);
        expQ.push_back(chan);
        cs = chan;
        for (int j = 0; j < 32; j++) begin
            b = data[8*j +: 8];
            expQ.push_back(b);
            cs = cs ^ b;
        end
        expQ.push_back(cs);
    endtask

    // Waits for IDLE, then presents the command for exactly one edge.
    task automatic applyStimulus(input logic isReset, input logic [7:0] chan);
        for (int i = 0; i < 2000 && !cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        cmd_reset = isReset;
        cmd_chan  = chan;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        accCyc    = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            done = !busy && (expQ.size() == 0);
        end
        checkOutput("frame_complete", {31'b0, done}, 32'd1);
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prevStall = 0;
            end else begin
                if (latWatch && tx_valid) begin
                    checkOutput("first_valid_latency", cyc - accCyc, 32'd11);
                    latWatch = 0;
                end
                if (prevStall) begin
                    checkOutput("stall_valid", {31'b0, tx_valid}, 32'd1);
                    checkOutput("stall_data", {24'b0, tx_data}, {24'b0, prevData});
                end
                if (tx_valid && tx_ready) begin
                    hsCount++;
                    if (!mute) begin
                        if (expQ.size() == 0) begin
                            checks++;
                            $display("[TB] FAIL unexpected_byte: got 0x%0h expected none", tx_data);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("frame_byte", {24'b0, tx_data}, {24'b0, e});
                        end
                    end
                end
                prevStall = tx_valid && !tx_ready;
                prevData  = tx_data;
            end
        end
    end

    initial begin : readyDriver
        forever begin
            @(posedge clk);
            #1;
            if (randReady) tx_ready = ($urandom_range(0, 9) < 3);
        end
    end

    initial begin : stimulus
        logic [255:0] dumpData, p0, p1, chan7Data;
        int           highCount;
        bit           readyLow;

        nrst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_reset = 1'b0;
        cmd_chan  = 8'h00;
        tx_ready  = 1'b1;
        dumpData  = makeWords(32'h0000_0003, 32'h0000_0100);
        p0        = makeWords(32'hCAFE_0000, 32'h0000_0001);
        p1        = makeWords(32'h1234_5600, 32'h0000_0011);
        chan7Data = makeWords(32'h0102_0304, 32'h1010_1010);
        histos_in = dumpData;

        $display("[TB] reset values");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_histostosend", {24'b0, histostosend}, 32'h0);
        checkOutput("rst_resethist", {31'b0, resethist}, 32'h0);
        checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkOutput("rst_tx_data", {24'b0, tx_data}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        $display("[TB] dump channel 3");
        pushFrame(8'hA5, 8'd3, dumpData);
        latWatch = 1;
        applyStimulus(1'b0, 8'd3);
        checkOutput("dump_histostosend", {24'b0, histostosend}, 32'd3);
        checkOutput("dump_busy", {31'b0, busy}, 32'd1);
        waitIdle(200);
        checkOutput("latency_seen", {31'b0, latWatch}, 32'd0);
        latWatch = 0;

        $display("[TB] clear histograms");
        applyStimulus(1'b1, 8'd0);
        highCount = 0;
        readyLow  = 1;
        for (int i = 0; i < 40 && resethist; i++) begin
            highCount++;
            if (cmd_ready) readyLow = 0;
            @(posedge clk);
            #1;
        end
        checkOutput("clear_cycles", highCount, 32'd16);
        checkOutput("clear_ready_low", {31'b0, readyLow}, 32'd1);
        checkOutput("clear_back_idle", {31'b0, cmd_ready}, 32'd1);

        $display("[TB] unstable input");
        histos_in = p0;
        applyStimulus(1'b0, 8'd9);
        // The fourth B sample lands 43 edges after acceptance and sees the value set after edge acc+42.
        pushFrame(8'hA6, 8'd9, (accCyc % 2 == 1) ? p1 : p0);
        histos_in = (cyc % 2 == 1) ? p1 : p0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            histos_in = (cyc % 2 == 1) ? p1 : p0;
        end
        histos_in = dumpData;
        waitIdle(300);

        $display("[TB] random backpressure");
        randReady = 1;
        pushFrame(8'hA5, 8'd3, dumpData);
        applyStimulus(1'b0, 8'd3);
        waitIdle(2000);
        randReady = 0;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;

        $display("[TB] out-of-range channel");
        pushFrame(8'hA5, 8'd20, 256'b0);
        applyStimulus(1'b0, 8'd20);
        checkOutput("oor_histostosend", {24'b0, histostosend}, 32'd3);
        waitIdle(200);

        $display("[TB] reset mid-frame");
        mute    = 1;
        hsCount = 0;
        applyStimulus(1'b0, 8'd5);
        for (int i = 0; i < 200 && hsCount < 10; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midframe_reached", {31'b0, hsCount >= 10}, 32'd1);
        nrst = 1'b0;
        #1;
        checkOutput("abort_resethist", {31'b0, resethist}, 32'h0);
        checkOutput("abort_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkOutput("abort_tx_data", {24'b0, tx_data}, 32'h0);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        checkOutput("abort_histostosend", {24'b0, histostosend}, 32'h0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        mute = 0;
        histos_in = chan7Data;
        pushFrame(8'hA5, 8'd7, chan7Data);
        applyStimulus(1'b0, 8'd7);
        waitIdle(200);

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
